cluster_count_scheduler: RTL and testbench

//  Sequences cluster readout behind the 1536-bit cluster counter. Delays the per-BX strobe by the

---
 rtl/cluster_count_scheduler.sv | 157 +++++++++++++++
 tb/tb_cluster_count_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_count_scheduler.sv
// Cluster readout scheduler. Lines each BX strobe up with the cluster counter's
// result, queues one entry per BX, and then hands out one readout slot per
// cluster to the packer over a valid/ready handshake.
module cluster_count_scheduler #(
  parameter int CNT_LATENCY  = 9,
  parameter int MAX_CLUSTERS = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock4x,
  input  logic        reset_n,
  input  logic        enable_i,
  input  logic        bx_strobe_i,
  input  logic [10:0] cnt_i,
  input  logic        slot_ready_i,
  output logic        slot_valid_o,
  output logic [2:0]  slot_idx_o,
  output logic        slot_last_o,
  output logic        bx_overflow_o,
  output logic        bx_done_o,
  output logic        fifo_full_o,
  output logic [7:0]  drop_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [10:0] MAX_CNT = 11'(MAX_CLUSTERS);
  localparam logic [3:0]  MAX_N   = 4'(MAX_CLUSTERS);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;

  state_t             state;
  logic [CNT_LATENCY-1:0] strobe_line;
  logic               tap;
  logic [3:0]         q_n   [FIFO_DEPTH];
  logic               q_ovf [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic               q_empty;
  logic               q_full;
  logic               push_req;
  logic               pop;
  logic               push_ok;
  logic               in_ovf;
  logic [3:0]         in_n;
  logic [3:0]         head_n;
  logic               head_ovf;
  logic [3:0]         n_r;

  // The strobe reaches the tap exactly when the counter result for that BX is valid.
  assign tap = strobe_line[CNT_LATENCY-1];

  // The extra pointer bit tells a full queue apart from an empty one.
  assign q_empty     = (wr_ptr == rd_ptr);
  assign q_full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_full_o = q_full;

  // Counts above the budget are clipped; the full 11-bit count sets the flag.
  assign in_ovf   = (cnt_i > MAX_CNT);
  assign in_n     = in_ovf ? MAX_N : cnt_i[3:0];
  assign push_req = tap && enable_i;
  assign pop      = (state == LOAD);
  // A pop in the same cycle frees the slot the push needs, so no drop then.
  assign push_ok  = push_req && (!q_full || pop);

  assign head_n   = q_n[rd_ptr[PTR_W-1:0]];
  assign head_ovf = q_ovf[rd_ptr[PTR_W-1:0]];

  // Shift the BX strobe along the counter-latency delay line.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      strobe_line <= '0;
    end else begin
      strobe_line <= {strobe_line[CNT_LATENCY-2:0], bx_strobe_i};
    end
  end

  // Queue storage; contents only matter between the pointers, so no reset needed.
  always_ff @(posedge clock4x) begin
    if (push_ok) begin
      q_n[wr_ptr[PTR_W-1:0]]   <= in_n;
      q_ovf[wr_ptr[PTR_W-1:0]] <= in_ovf;
    end
  end

  // Queue pointers and the saturating count of samples lost to a full queue.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_req && !push_ok && (drop_cnt_o != 8'hFF)) begin
        drop_cnt_o <= drop_cnt_o + 8'd1;
      end
    end
  end

  // Readout FSM: load one BX entry, then offer its slots one at a time.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      n_r           <= '0;
      slot_valid_o  <= 1'b0;
      slot_idx_o    <= '0;
      slot_last_o   <= 1'b0;
      bx_overflow_o <= 1'b0;
      bx_done_o     <= 1'b0;
    end else begin
      bx_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!q_empty) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          n_r <= head_n;
          if (head_n == 4'd0) begin
            bx_done_o <= 1'b1;
            state     <= IDLE;
          end else begin
            slot_valid_o  <= 1'b1;
            slot_idx_o    <= 3'd0;
            slot_last_o   <= (head_n == 4'd1);
            bx_overflow_o <= head_ovf;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (slot_ready_i) begin
            if (slot_last_o) begin
              slot_valid_o  <= 1'b0;
              slot_idx_o    <= 3'd0;
              slot_last_o   <= 1'b0;
              bx_overflow_o <= 1'b0;
              bx_done_o     <= 1'b1;
              state         <= IDLE;
            end else begin
              slot_idx_o  <= slot_idx_o + 3'd1;
              slot_last_o <= (({1'b0, slot_idx_o} + 4'd2) == n_r);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_count_scheduler.sv
// Bench for cluster_count_scheduler: directed scenarios followed by randomized
// traffic, checked against a transaction-level model of the expected slots.
module tb_cluster_count_scheduler;

  logic        clock4x = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable_i = 1'b0;
  logic        bx_strobe_i = 1'b0;
  logic [10:0] cnt_i = '0;
  logic        slot_ready_i = 1'b0;
  logic        slot_valid_o;
  logic [2:0]  slot_idx_o;
  logic        slot_last_o;
  logic        bx_overflow_o;
  logic        bx_done_o;
  logic        fifo_full_o;
  logic [7:0]  drop_cnt_o;

  cluster_count_scheduler dut (
    .clock4x      (clock4x),
    .reset_n      (reset_n),
    .enable_i     (enable_i),
    .bx_strobe_i  (bx_strobe_i),
    .cnt_i        (cnt_i),
    .slot_ready_i (slot_ready_i),
    .slot_valid_o (slot_valid_o),
    .slot_idx_o   (slot_idx_o),
    .slot_last_o  (slot_last_o),
    .bx_overflow_o(bx_overflow_o),
    .bx_done_o    (bx_done_o),
    .fifo_full_o  (fifo_full_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clock4x = ~clock4x;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic       ovf;
  } slot_t;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    tap_cyc[$];
  int    tap_cnt[$];
  int    next_cnt = 0;
  slot_t exp_slots[$];
  int    exp_done = 0;
  int    done_seen = 0;
  int    outstanding = 0;
  int    exp_drop = 0;
  int    slots_acc = 0;
  int    valid_cycles = 0;
  int    first_valid = -1;
  logic  prev_hold = 1'b0;
  logic [2:0] prev_idx = '0;
  logic  prev_last = 1'b0;
  logic  prev_ovf = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // A BX sample enters the model: it yields min(cnt,8) slots, flagged when cnt > 8.
  // At most one BX in service plus four queued may be outstanding; beyond that it is lost.
  task automatic model_push(input int c);
    int    n;
    slot_t s;
    n = (c > 8) ? 8 : c;
    if (outstanding >= 5) begin
      if (exp_drop < 255) exp_drop++;
    end else begin
      outstanding++;
      exp_done++;
      for (int i = 0; i < n; i++) begin
        s.idx  = 3'(i);
        s.last = (i == n - 1);
        s.ovf  = (c > 8);
        exp_slots.push_back(s);
      end
    end
  endtask

  // Mid-cycle observation of the outputs against the model.
  task automatic monitor();
    slot_t s;
    if (prev_hold) begin
      check_output("hold_valid", slot_valid_o, 1);
      check_output("hold_idx", slot_idx_o, prev_idx);
      check_output("hold_last", slot_last_o, prev_last);
      check_output("hold_ovf", bx_overflow_o, prev_ovf);
    end
    if (bx_done_o) begin
      done_seen++;
      outstanding--;
    end
    if (slot_valid_o) begin
      valid_cycles++;
      if (first_valid < 0) first_valid = cyc;
      if (slot_ready_i) begin
        slots_acc++;
        if (exp_slots.size() == 0) begin
          check_output("slot_expected", exp_slots.size(), 1);
        end else begin
          s = exp_slots.pop_front();
          check_output("slot_idx", slot_idx_o, s.idx);
          check_output("slot_last", slot_last_o, s.last);
          check_output("slot_ovf", bx_overflow_o, s.ovf);
        end
      end
    end
    prev_hold = slot_valid_o && !slot_ready_i;
    prev_idx  = slot_idx_o;
    prev_last = slot_last_o;
    prev_ovf  = bx_overflow_o;
  endtask

  // One clock cycle: present the counter value at tap time, observe, advance.
  task automatic apply_stimulus();
    if (tap_cyc.size() > 0 && tap_cyc[0] == cyc) begin
      cnt_i = 11'(tap_cnt[0]);
      if (enable_i) model_push(tap_cnt[0]);
      void'(tap_cyc.pop_front());
      void'(tap_cnt.pop_front());
    end else begin
      cnt_i = 11'($urandom);
    end
    if (bx_strobe_i) begin
      tap_cyc.push_back(cyc + 9);
      tap_cnt.push_back(next_cnt);
    end
    @(negedge clock4x);
    monitor();
    @(posedge clock4x);
    #1;
    cyc++;
    bx_strobe_i = 1'b0;
  endtask

  task automatic strobe(input int c);
    next_cnt    = c;
    bx_strobe_i = 1'b1;
    apply_stimulus();
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!slot_valid_o && k < budget) begin
      apply_stimulus();
      k++;
    end
    check_output("valid_seen", slot_valid_o, 1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    slot_ready_i = 1'b1;
    while (!(tap_cyc.size() == 0 && exp_slots.size() == 0 && done_seen == exp_done) && k < budget) begin
      apply_stimulus();
      k++;
    end
    check_output("drain_complete", (k < budget), 1);
    apply_stimulus();
    apply_stimulus();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_output({tag, "_valid"}, slot_valid_o, 0);
    check_output({tag, "_idx"}, slot_idx_o, 0);
    check_output({tag, "_last"}, slot_last_o, 0);
    check_output({tag, "_ovf"}, bx_overflow_o, 0);
    check_output({tag, "_done"}, bx_done_o, 0);
    check_output({tag, "_full"}, fifo_full_o, 0);
    check_output({tag, "_drop"}, drop_cnt_o, 0);
  endtask

  // Reset throws away everything in flight, including an unfinished BX.
  task automatic model_flush();
    exp_slots.delete();
    tap_cyc.delete();
    tap_cnt.delete();
    outstanding = 0;
    exp_drop    = 0;
    exp_done    = done_seen;
    prev_hold   = 1'b0;
  endtask

  initial begin
    int s0;
    int d0;
    int a0;
    int v0;
    int gap;

    // Reset state
    #1;
    check_outputs_zero("reset");
    apply_stimulus();
    apply_stimulus();
    reset_n  = 1'b1;
    enable_i = 1'b1;
    apply_stimulus();

    // T1 latency: strobe, count 3 at tap time, first slot 12 cycles after strobe
    slot_ready_i = 1'b1;
    first_valid  = -1;
    s0 = cyc;
    a0 = slots_acc;
    d0 = done_seen;
    strobe(3);
    drain(60);
    check_output("t1_first_valid_cycle", first_valid, s0 + 12);
    check_output("t1_slots", slots_acc - a0, 3);
    check_output("t1_done", done_seen - d0, 1);

    // T2 overflow: count 12 is clipped to 8 flagged slots
    a0 = slots_acc;
    d0 = done_seen;
    strobe(12);
    drain(80);
    check_output("t2_slots", slots_acc - a0, 8);
    check_output("t2_done", done_seen - d0, 1);

    // T3 backpressure: ready pattern 0,1,0,0,1 over a two-slot BX
    slot_ready_i = 1'b0;
    a0 = slots_acc;
    strobe(2);
    wait_valid(40);
    slot_ready_i = 1'b0; apply_stimulus();
    slot_ready_i = 1'b1; apply_stimulus();
    slot_ready_i = 1'b0; apply_stimulus();
    slot_ready_i = 1'b0; apply_stimulus();
    slot_ready_i = 1'b1; apply_stimulus();
    slot_ready_i = 1'b0;
    check_output("t3_slots", slots_acc - a0, 2);
    check_output("t3_valid_after", slot_valid_o, 0);
    drain(60);

    // T4 full queue: six single-slot BXs with the packer stalled
    slot_ready_i = 1'b0;
    d0 = done_seen;
    for (int i = 0; i < 6; i++) begin
      strobe(1);
      apply_stimulus();
      apply_stimulus();
      apply_stimulus();
    end
    for (int i = 0; i < 12; i++) apply_stimulus();
    check_output("t4_full", fifo_full_o, 1);
    check_output("t4_drop", drop_cnt_o, exp_drop);
    check_output("t4_no_done_yet", done_seen - d0, 0);
    drain(200);
    check_output("t4_done", done_seen - d0, 5);

    // T5 zero count: retire pulse without any slot
    v0 = valid_cycles;
    d0 = done_seen;
    strobe(0);
    drain(60);
    check_output("t5_zero_valid", valid_cycles - v0, 0);
    check_output("t5_zero_done", done_seen - d0, 1);

    // T5 enable low at tap time only: nothing queued
    d0 = done_seen;
    a0 = slots_acc;
    strobe(4);
    for (int i = 0; i < 5; i++) apply_stimulus();
    enable_i = 1'b0;
    for (int i = 0; i < 6; i++) apply_stimulus();
    enable_i = 1'b1;
    drain(60);
    check_output("t5_disabled_done", done_seen - d0, 0);
    check_output("t5_disabled_slots", slots_acc - a0, 0);

    // T5 enable low at strobe time but high at tap time: queued normally
    d0 = done_seen;
    enable_i = 1'b0;
    strobe(2);
    apply_stimulus();
    enable_i = 1'b1;
    drain(60);
    check_output("t5_late_enable_done", done_seen - d0, 1);

    // T6 asynchronous reset in the middle of a five-slot BX
    slot_ready_i = 1'b0;
    strobe(5);
    wait_valid(40);
    slot_ready_i = 1'b1;
    apply_stimulus();
    check_output("t6_mid_issue", slot_valid_o, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    model_flush();
    d0 = done_seen;
    apply_stimulus();
    apply_stimulus();
    check_output("t6_no_done", done_seen - d0, 0);
    reset_n = 1'b1;
    a0 = slots_acc;
    strobe(1);
    drain(60);
    check_output("t6_after_slots", slots_acc - a0, 1);
    check_output("t6_after_done", done_seen - d0, 1);

    // Randomized traffic: counts (some far above the budget), enable and ready
    for (int b = 0; b < 25; b++) begin
      next_cnt    = (($urandom % 4) == 0) ? int'($urandom_range(9, 2047)) : int'($urandom_range(0, 12));
      bx_strobe_i = 1'b1;
      gap = int'($urandom_range(40, 60));
      for (int g = 0; g < gap; g++) begin
        enable_i     = (($urandom % 5) != 0);
        slot_ready_i = (($urandom % 10) < 7);
        apply_stimulus();
      end
    end
    enable_i = 1'b1;
    drain(400);
    check_output("final_done", done_seen, exp_done);
    check_output("final_drop", drop_cnt_o, exp_drop);
    check_output("final_slots_left", exp_slots.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
